bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble),
// consuming one input bit per clock; results held until the next completion.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    work;
    logic [BW-1:0]    adj;
    logic [BW-1:0]    work_nx;
    logic             ovf_w;
    logic             ovf_nx;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;

    // Per-digit add-3 correction ahead of the shift.
    always_comb begin
        adj = work;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        work_nx = {adj[BW-2:0], shreg[WIDTH-1]};
        ovf_nx  = ovf_w | adj[BW-1];
        last    = (cnt == CW'(1));
        accept  = start && (state != SHIFT);
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last)
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? SHIFT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            work     <= '0;
            ovf_w    <= 1'b0;
            cnt      <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            shreg <= bin;
            work  <= '0;
            ovf_w <= 1'b0;
            cnt   <= CW'(WIDTH);
        end else if (state == SHIFT) begin
            shreg <= shreg << 1;
            work  <= work_nx;
            ovf_w <= ovf_nx;
            cnt   <= cnt - CW'(1);
            // Final shift result goes straight to the outputs on the DONE edge.
            if (last) begin
                bcd      <= work_nx;
                overflow <= ovf_nx;
            end
        end
    end

endmodule
